// File: rtl/ultrasonido_presencia.sv
// HC-SR04 ranging: trigger, echo width to centimetres,
// and a hysteresis-filtered presence flag for the LCD wake-up.
module ultrasonido_presencia #(
  parameter int unsigned TRIG_CYCLES         = 500,
  parameter int unsigned GAP_CYCLES          = 3000000,
  parameter int unsigned ECHO_TIMEOUT_CYCLES = 1500000,
  parameter int unsigned CYCLES_PER_CM       = 2900,
  parameter int unsigned THRESHOLD_CM        = 30,
  parameter int unsigned HITS                = 3,
  parameter int unsigned DIST_BITS           = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 echo,
  output logic                 trig,
  output logic                 distancia,
  output logic [DIST_BITS-1:0] distance_cm,
  output logic                 meas_valid,
  output logic                 timeout
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(TRIG_CYCLES + 1);
  localparam int OW = $clog2(ECHO_TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(CYCLES_PER_CM + 1);
  localparam int HW = $clog2(HITS + 1);

  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES);
  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES - 1);
  localparam logic [OW-1:0] TO_LAST   = OW'(ECHO_TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PS_LAST   = PW'(CYCLES_PER_CM - 1);
  localparam logic [HW-1:0] HIT_MAX   = HW'(HITS);
  localparam logic [DIST_BITS-1:0] CM_MAX = '1;
  localparam logic [DIST_BITS-1:0] THR    = DIST_BITS'(THRESHOLD_CM);

  typedef enum logic [2:0] {
    IDLE, TRIGGER, WAIT_RISE, MEASURE, EVALUATE
  } state_t;

  state_t state_q, state_d;

  logic [GW-1:0] gap_q;
  logic [TW-1:0] trig_cnt_q;
  logic [OW-1:0] to_q;
  logic [PW-1:0] ps_q;
  logic [DIST_BITS-1:0] cm_q, cm_inc, cm_res;
  logic [HW-1:0] near_q, far_q, near_nx, far_nx;
  logic echo_m, echo_s, echo_p;
  logic rise, fall, ev_to, ps_wrap, near, stay;

  assign rise = echo_s & ~echo_p;
  assign fall = ~echo_s & echo_p;

  assign ps_wrap = (ps_q == PS_LAST);
  assign cm_inc  = (ps_wrap && cm_q != CM_MAX) ?
                   cm_q + DIST_BITS'(1) : cm_q;
  assign stay    = (state_d == state_q);

  assign near    = !timeout && (distance_cm < THR);
  assign near_nx = (near_q == HIT_MAX) ? near_q : near_q + HW'(1);
  assign far_nx  = (far_q == HIT_MAX) ? far_q : far_q + HW'(1);

  always_comb begin
    state_d = state_q;
    ev_to   = 1'b0;
    unique case (state_q)
      IDLE:
        if (gap_q == GAP_LAST) state_d = TRIGGER;
      TRIGGER:
        if (trig_cnt_q == TRIG_LAST) state_d = WAIT_RISE;
      WAIT_RISE:
        if (rise) begin
          state_d = MEASURE;
        end else if (to_q == TO_LAST) begin
          state_d = EVALUATE;
          ev_to   = 1'b1;
        end
      MEASURE:
        // A falling edge beats a coincident timeout.
        if (fall) begin
          state_d = EVALUATE;
        end else if (to_q == TO_LAST) begin
          state_d = EVALUATE;
          ev_to   = 1'b1;
        end
      EVALUATE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    cm_res = '0;
    if (state_q == MEASURE) cm_res = ev_to ? CM_MAX : cm_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      trig_cnt_q  <= '0;
      to_q        <= '0;
      ps_q        <= '0;
      cm_q        <= '0;
      near_q      <= '0;
      far_q       <= '0;
      echo_m      <= 1'b0;
      echo_s      <= 1'b0;
      echo_p      <= 1'b0;
      trig        <= 1'b0;
      distancia   <= 1'b0;
      distance_cm <= '0;
      meas_valid  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_p <= echo_s;
      if (!enable) begin
        state_q    <= IDLE;
        gap_q      <= '0;
        trig_cnt_q <= '0;
        to_q       <= '0;
        ps_q       <= '0;
        cm_q       <= '0;
        near_q     <= '0;
        far_q      <= '0;
        trig       <= 1'b0;
        distancia  <= 1'b0;
        meas_valid <= 1'b0;
        timeout    <= 1'b0;
      end else begin
        state_q    <= state_d;
        trig       <= (state_d == TRIGGER);
        meas_valid <= (state_d == EVALUATE);
        timeout    <= ev_to;
        gap_q      <= (state_q == IDLE && stay) ?
                      gap_q + GW'(1) : '0;
        trig_cnt_q <= (state_q == TRIGGER && stay) ?
                      trig_cnt_q + TW'(1) : '0;
        to_q       <= (stay && (state_q == WAIT_RISE ||
                                state_q == MEASURE)) ?
                      to_q + OW'(1) : '0;
        ps_q       <= (state_q == MEASURE && stay) ?
                      (ps_wrap ? '0 : ps_q + PW'(1)) : '0;
        cm_q       <= (state_q == MEASURE && stay) ? cm_inc : '0;
        if (state_d == EVALUATE) distance_cm <= cm_res;
        if (state_q == EVALUATE) begin
          if (near) begin
            near_q <= near_nx;
            far_q  <= '0;
            if (near_nx == HIT_MAX) distancia <= 1'b1;
          end else begin
            far_q  <= far_nx;
            near_q <= '0;
            if (far_nx == HIT_MAX) distancia <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ultrasonido_presencia.sv
// Directed bench for ultrasonido_presencia with shrunk timing
// parameters; expected values are hand-derived per scenario.
module tb_ultrasonido_presencia;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       echo = 1'b0;
  logic       trig, distancia, meas_valid, timeout;
  logic [8:0] distance_cm;

  int checks = 0;
  int errors = 0;

  ultrasonido_presencia #(
    .TRIG_CYCLES(5), .GAP_CYCLES(20), .ECHO_TIMEOUT_CYCLES(400),
    .CYCLES_PER_CM(4), .THRESHOLD_CM(30), .HITS(3), .DIST_BITS(9)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .echo(echo),
    .trig(trig), .distancia(distancia), .distance_cm(distance_cm),
    .meas_valid(meas_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits out the next trigger pulse; returns just after trig falls.
  task automatic wait_trig_done();
    int  n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (trig !== 1'b1 && n < 200) begin step(); n++; end
    if (trig === 1'b1) seen = 1'b1;
    while (trig === 1'b1 && n < 400) begin step(); n++; end
    checks++;
    if (!seen || trig !== 1'b0) begin
      errors++;
      $display("FAIL trig_pulse: seen=%b trig=%b after %0d cycles, required full pulse",
               seen, trig, n);
    end
  endtask

  // w>0: echo pulse of w cycles; w==0: no echo; w<0: echo held high.
  task automatic meas(input int w, output logic [8:0] d,
                      output logic to, output logic strobe2,
                      output logic dz, output int lat);
    lat = 0;
    if (w != 0) echo = 1'b1;
    for (int i = 0; i < w; i++) begin step(); lat++; end
    if (w > 0) echo = 1'b0;
    while (meas_valid !== 1'b1 && lat < 2000) begin step(); lat++; end
    checks++;
    if (meas_valid !== 1'b1) begin
      errors++;
      $display("FAIL meas_wait: meas_valid=%b after %0d cycles, required 1",
               meas_valid, lat);
    end
    d = distance_cm;
    to = timeout;
    step();
    strobe2 = meas_valid | timeout;
    dz = distancia;
  endtask

  task automatic test_reset();
    int n;
    logic bad;
    reset = 1'b1; enable = 1'b1; echo = 1'b0;
    repeat (3) step();
    checks++;
    if ({trig, distancia, meas_valid, timeout} !== 4'b0 ||
        distance_cm !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: trig=%b dist=%b mv=%b to=%b cm=%0d, required all 0",
               trig, distancia, meas_valid, timeout, distance_cm);
    end
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (trig | distancia | meas_valid | timeout | (|distance_cm))
        bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL pre_trig_quiet: outputs active=%b, required 0", bad);
    end
    step();
    checks++;
    if (trig !== 1'b1) begin
      errors++;
      $display("FAIL trig_rise_21: trig=%b at cycle 21, required 1", trig);
    end
    n = 0;
    while (trig === 1'b1 && n < 50) begin n++; step(); end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL trig_width: %0d cycles, required 5", n);
    end
  endtask

  task automatic test_near();
    int         wid[4] = '{40, 40, 40, 43};
    logic [8:0] ecm[4] = '{10, 10, 10, 10};
    logic       ez[4]  = '{0, 0, 1, 1};
    logic [8:0] d;
    logic       to, s2, dz;
    int         lat;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) wait_trig_done();
      meas(wid[i], d, to, s2, dz, lat);
      checks++;
      if (d !== ecm[i] || to !== 1'b0 || s2 !== 1'b0 ||
          dz !== ez[i] || lat != wid[i] + 3) begin
        errors++;
        $display("FAIL near_%0d: cm=%0d to=%b strobe2=%b dist=%b lat=%0d, required cm=%0d to=0 strobe2=0 dist=%b lat=%0d",
                 i, d, to, s2, dz, lat, ecm[i], ez[i], wid[i] + 3);
      end
    end
  endtask

  task automatic test_hysteresis();
    int wid[21] = '{200, 40, 200, 200, 200,
                    40, 200, 40, 200,
                    40, 40, 200, 40, 40, 40,
                    120, 120, 120, 116, 116, 116};
    int ecm[21] = '{50, 10, 50, 50, 50,
                    10, 50, 10, 50,
                    10, 10, 50, 10, 10, 10,
                    30, 30, 30, 29, 29, 29};
    logic ez[21] = '{1, 1, 1, 1, 0,
                     0, 0, 0, 0,
                     0, 0, 0, 0, 0, 1,
                     1, 1, 0, 0, 0, 1};
    logic [8:0] d;
    logic       to, s2, dz;
    int         lat;
    for (int i = 0; i < 21; i++) begin
      wait_trig_done();
      meas(wid[i], d, to, s2, dz, lat);
      checks++;
      if (d !== 9'(ecm[i]) || to !== 1'b0 || s2 !== 1'b0 ||
          dz !== ez[i]) begin
        errors++;
        $display("FAIL hyst_%0d: w=%0d cm=%0d to=%b strobe2=%b dist=%b, required cm=%0d to=0 strobe2=0 dist=%b",
                 i, wid[i], d, to, s2, dz, ecm[i], ez[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int         mode[3] = '{0, -1, -1};
    int         elat[3] = '{400, 403, 400};
    logic [8:0] ecm[3]  = '{0, 511, 0};
    logic       ez[3]   = '{1, 1, 0};
    logic [8:0] d;
    logic       to, s2, dz;
    int         lat;
    for (int i = 0; i < 3; i++) begin
      wait_trig_done();
      meas(mode[i], d, to, s2, dz, lat);
      checks++;
      if (d !== ecm[i] || to !== 1'b1 || s2 !== 1'b0 ||
          dz !== ez[i] || lat != elat[i]) begin
        errors++;
        $display("FAIL timeout_%0d: cm=%0d to=%b strobe2=%b dist=%b lat=%0d, required cm=%0d to=1 strobe2=0 dist=%b lat=%0d",
                 i, d, to, s2, dz, lat, ecm[i], ez[i], elat[i]);
      end
    end
    echo = 1'b0;
  endtask

  task automatic test_enable();
    logic [8:0] d;
    logic       to, s2, dz;
    int         lat, n;
    for (int i = 0; i < 3; i++) begin
      wait_trig_done();
      meas(40, d, to, s2, dz, lat);
    end
    checks++;
    if (dz !== 1'b1 || d !== 9'd10) begin
      errors++;
      $display("FAIL enable_setup: dist=%b cm=%0d, required dist=1 cm=10", dz, d);
    end
    wait_trig_done();
    echo = 1'b1;
    repeat (20) step();
    enable = 1'b0;
    step();
    checks++;
    if (trig !== 1'b0 || distancia !== 1'b0 || distance_cm !== 9'd10 ||
        meas_valid !== 1'b0) begin
      errors++;
      $display("FAIL enable_drop: trig=%b dist=%b cm=%0d mv=%b, required 0 0 10 0",
               trig, distancia, distance_cm, meas_valid);
    end
    echo = 1'b0;
    repeat (5) step();
    enable = 1'b1;
    n = 0;
    while (trig !== 1'b1 && n < 100) begin step(); n++; end
    checks++;
    if (n != 21) begin
      errors++;
      $display("FAIL reenable_gap: trig after %0d cycles, required 21", n);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    reset = 1'b1;
    step();
    checks++;
    if (trig !== 1'b0 || distance_cm !== 9'd0) begin
      errors++;
      $display("FAIL reset_abort: trig=%b cm=%0d, required 0 0", trig, distance_cm);
    end
    reset = 1'b0;
    n = 0;
    while (trig !== 1'b1 && n < 100) begin step(); n++; end
    checks++;
    if (n != 21) begin
      errors++;
      $display("FAIL reset_regap: trig after %0d cycles, required 21", n);
    end
  endtask

  initial begin
    test_reset();
    test_near();
    test_hysteresis();
    test_timeout();
    test_enable();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
